// File: rtl/atm_session_controller_if.sv
// Signal bundle between the session controller, the keypad and the account core.
// slave: the session controller. master: the environment (keypad + core).
interface atm_session_controller_if;
  logic       key_valid;
  logic [3:0] key_data;
  logic       cancel;
  logic       req;
  logic [1:0] req_select;
  logic [3:0] req_origin;
  logic [3:0] req_purpose;
  logic [9:0] req_amount;
  logic       ack;
  logic [1:0] rsp_result;
  logic [9:0] rsp_inventory;
  logic       busy;
  logic       disp_valid;
  logic [1:0] disp_result;
  logic [9:0] disp_inventory;
  logic       timeout_err;

  modport master (
    output key_valid, key_data, cancel, ack, rsp_result, rsp_inventory,
    input  req, req_select, req_origin, req_purpose, req_amount,
           busy, disp_valid, disp_result, disp_inventory, timeout_err
  );

  modport slave (
    input  key_valid, key_data, cancel, ack, rsp_result, rsp_inventory,
    output req, req_select, req_origin, req_purpose, req_amount,
           busy, disp_valid, disp_result, disp_inventory, timeout_err
  );
endinterface

// File: rtl/atm_session_controller.sv
// ATM session front end: collects keypad nibbles into one transaction, issues it
// to the account core over req/ack, and shows the core's answer for a fixed time.
module atm_session_controller #(
  parameter int IDLE_TIMEOUT   = 1000,
  parameter int ACK_TIMEOUT    = 64,
  parameter int DISPLAY_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  atm_session_controller_if.slave   bus
);
  localparam int MAXP = (IDLE_TIMEOUT > ACK_TIMEOUT) ?
                        ((IDLE_TIMEOUT > DISPLAY_CYCLES) ? IDLE_TIMEOUT : DISPLAY_CYCLES) :
                        ((ACK_TIMEOUT > DISPLAY_CYCLES) ? ACK_TIMEOUT : DISPLAY_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] DISP_LAST = CW'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_SEL, S_GET_DEST, S_GET_AMT0, S_GET_AMT1, S_GET_AMT2, S_ISSUE, S_SHOW
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    r_origin, w_origin;
  logic [1:0]    r_sel, w_sel;
  logic [3:0]    r_purpose, w_purpose;
  logic [9:0]    r_amount, w_amount;
  logic          r_req, w_req;
  logic          r_busy;
  logic          r_disp_valid, w_disp_valid;
  logic [1:0]    r_disp_result, w_disp_result;
  logic [9:0]    r_disp_inv, w_disp_inv;
  logic          r_tmo, w_tmo;
  logic          w_key;
  logic          w_entry;

  // Saturating increment: the shared cycle counter never wraps.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_key   = bus.key_valid && !bus.cancel;
  assign w_entry = r_state inside {S_GET_SEL, S_GET_DEST, S_GET_AMT0, S_GET_AMT1, S_GET_AMT2};

  // Next-state, next-field and next-output decode for the session FSM.
  always_comb begin
    w_state       = r_state;
    w_cnt         = sat_inc(r_cnt);
    w_origin      = r_origin;
    w_sel         = r_sel;
    w_purpose     = r_purpose;
    w_amount      = r_amount;
    w_req         = 1'b0;
    w_disp_valid  = 1'b0;
    w_disp_result = r_disp_result;
    w_disp_inv    = r_disp_inv;
    w_tmo         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (bus.key_valid) begin
          w_origin = bus.key_data;
          w_state  = S_GET_SEL;
        end
      end
      S_GET_SEL: begin
        if (w_key) begin
          w_sel     = bus.key_data[1:0];
          w_purpose = '0;
          w_amount  = '0;
          case (bus.key_data[1:0])
            2'b11:   w_state = S_IDLE;
            2'b00: begin
              w_state = S_ISSUE;
              w_req   = 1'b1;
            end
            2'b01:   w_state = S_GET_AMT0;
            default: w_state = S_GET_DEST;
          endcase
        end
      end
      S_GET_DEST: begin
        if (w_key) begin
          w_purpose = bus.key_data;
          w_state   = S_GET_AMT0;
        end
      end
      S_GET_AMT0: begin
        if (w_key) begin
          w_amount[9:8] = bus.key_data[1:0];
          w_state       = S_GET_AMT1;
        end
      end
      S_GET_AMT1: begin
        if (w_key) begin
          w_amount[7:4] = bus.key_data;
          w_state       = S_GET_AMT2;
        end
      end
      S_GET_AMT2: begin
        if (w_key) begin
          w_amount[3:0] = bus.key_data;
          w_state       = S_ISSUE;
          w_req         = 1'b1;
        end
      end
      S_ISSUE: begin
        // Once issued the request runs to ack or timeout; keys and cancel are ignored.
        w_req = 1'b1;
        if (bus.ack) begin
          w_disp_result = bus.rsp_result;
          w_disp_inv    = bus.rsp_inventory;
          w_req         = 1'b0;
          w_disp_valid  = 1'b1;
          w_cnt         = '0;
          w_state       = S_SHOW;
        end else if (r_cnt == ACK_LAST) begin
          w_req   = 1'b0;
          w_tmo   = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_SHOW: begin
        w_disp_valid = 1'b1;
        if (bus.cancel || r_cnt == DISP_LAST) begin
          w_disp_valid = 1'b0;
          w_state      = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Common entry-state handling: cancel beats a simultaneous key, a key restarts
    // the inactivity count (which also covers state entry), otherwise time out.
    if (w_entry) begin
      if (bus.cancel) begin
        w_state = S_IDLE;
      end else if (w_key) begin
        w_cnt = '0;
      end else if (r_cnt == IDLE_LAST) begin
        w_state = S_IDLE;
        w_tmo   = 1'b1;
      end
    end
  end

  // State, captured fields and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_origin      <= '0;
      r_sel         <= '0;
      r_purpose     <= '0;
      r_amount      <= '0;
      r_req         <= 1'b0;
      r_busy        <= 1'b0;
      r_disp_valid  <= 1'b0;
      r_disp_result <= '0;
      r_disp_inv    <= '0;
      r_tmo         <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_origin      <= w_origin;
      r_sel         <= w_sel;
      r_purpose     <= w_purpose;
      r_amount      <= w_amount;
      r_req         <= w_req;
      r_busy        <= (w_state != S_IDLE);
      r_disp_valid  <= w_disp_valid;
      r_disp_result <= w_disp_result;
      r_disp_inv    <= w_disp_inv;
      r_tmo         <= w_tmo;
    end
  end

  assign bus.req            = r_req;
  assign bus.req_select     = r_sel;
  assign bus.req_origin     = r_origin;
  assign bus.req_purpose    = r_purpose;
  assign bus.req_amount     = r_amount;
  assign bus.busy           = r_busy;
  assign bus.disp_valid     = r_disp_valid;
  assign bus.disp_result    = r_disp_result;
  assign bus.disp_inventory = r_disp_inv;
  assign bus.timeout_err    = r_tmo;
endmodule

// File: tb/tb_atm_session_controller.sv
// Scoreboard bench for atm_session_controller: stimulus queues the expected
// request/display/timeout events, a negedge monitor pops and compares them.
module tb_atm_session_controller;
  localparam int IDLE_TIMEOUT   = 1000;
  localparam int ACK_TIMEOUT    = 64;
  localparam int DISPLAY_CYCLES = 500;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] org;
    logic [3:0] pur;
    logic [9:0] amt;
    int         len;
  } req_exp_t;

  typedef struct {
    logic [1:0] res;
    logic [9:0] inv;
    int         len;
  } disp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  atm_session_controller_if bus();

  atm_session_controller #(
    .IDLE_TIMEOUT  (IDLE_TIMEOUT),
    .ACK_TIMEOUT   (ACK_TIMEOUT),
    .DISPLAY_CYCLES(DISPLAY_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int        n_vec = 0;
  int        n_err = 0;
  req_exp_t  req_q[$];
  disp_exp_t disp_q[$];
  int        tmo_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // ---------------- monitor ----------------
  logic      req_prev = 1'b0, disp_prev = 1'b0, tmo_prev = 1'b0;
  bit        have_req = 0, have_disp = 0;
  int        req_len = 0, disp_len = 0, tmo_len = 0;
  req_exp_t  cur_r;
  disp_exp_t cur_d;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.req && !req_prev) begin
        req_len = 1;
        if (req_q.size() == 0) begin
          unexpected("req_rise");
          have_req = 0;
        end else begin
          cur_r = req_q.pop_front();
          have_req = 1;
          chk("req_select", 32'(bus.req_select), 32'(cur_r.sel));
          chk("req_origin", 32'(bus.req_origin), 32'(cur_r.org));
          chk("req_purpose", 32'(bus.req_purpose), 32'(cur_r.pur));
          chk("req_amount", 32'(bus.req_amount), 32'(cur_r.amt));
        end
      end else if (bus.req && req_prev) begin
        req_len++;
        if (have_req)
          chk("req_stable", {12'd0, bus.req_select, bus.req_origin, bus.req_purpose, bus.req_amount},
              {12'd0, cur_r.sel, cur_r.org, cur_r.pur, cur_r.amt});
      end else if (!bus.req && req_prev && have_req) begin
        chk("req_len", 32'(req_len), 32'(cur_r.len));
        have_req = 0;
      end
      req_prev = bus.req;

      if (bus.disp_valid && !disp_prev) begin
        disp_len = 1;
        if (disp_q.size() == 0) begin
          unexpected("disp_rise");
          have_disp = 0;
        end else begin
          cur_d = disp_q.pop_front();
          have_disp = 1;
          chk("disp_result", 32'(bus.disp_result), 32'(cur_d.res));
          chk("disp_inventory", 32'(bus.disp_inventory), 32'(cur_d.inv));
        end
      end else if (bus.disp_valid && disp_prev) begin
        disp_len++;
      end else if (!bus.disp_valid && disp_prev && have_disp) begin
        chk("disp_len", 32'(disp_len), 32'(cur_d.len));
        have_disp = 0;
      end
      disp_prev = bus.disp_valid;

      if (bus.timeout_err && !tmo_prev) begin
        tmo_len = 1;
        if (tmo_q.size() == 0) unexpected("timeout_err");
        else void'(tmo_q.pop_front());
      end else if (bus.timeout_err && tmo_prev) begin
        tmo_len++;
      end else if (!bus.timeout_err && tmo_prev) begin
        chk("tmo_width", 32'(tmo_len), 32'd1);
      end
      tmo_prev = bus.timeout_err;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic key(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_data  = k;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_data  = 4'h0;
  endtask

  task automatic wait_req();
    int i;
    for (i = 0; i < 20; i++) begin
      if (bus.req) break;
      @(posedge clk); #1;
    end
    if (!bus.req) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: req never rose, got 0 want 1");
    end
  endtask

  // Ack d cycles after req rose; optionally poke cancel+key in the first req cycle.
  task automatic do_ack(input int d, input logic [1:0] res, input logic [9:0] inv, input bit poke);
    for (int i = 0; i < d; i++) begin
      if (poke && i == 0) begin
        bus.cancel = 1'b1; bus.key_valid = 1'b1; bus.key_data = 4'h3;
      end
      @(posedge clk); #1;
      bus.cancel = 1'b0; bus.key_valid = 1'b0; bus.key_data = 4'h0;
    end
    bus.ack = 1'b1; bus.rsp_result = res; bus.rsp_inventory = inv;
    @(posedge clk); #1;
    bus.ack = 1'b0; bus.rsp_result = 2'b00; bus.rsp_inventory = 10'h0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!bus.busy && !bus.disp_valid) break;
      @(posedge clk); #1;
    end
    if (bus.busy || bus.disp_valid) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy=%0b disp_valid=%0b want 0", bus.busy, bus.disp_valid);
    end
  endtask

  function automatic req_exp_t mk_req(input logic [1:0] s, input logic [3:0] o,
                                      input logic [3:0] p, input logic [9:0] a, input int l);
    req_exp_t r;
    r.sel = s; r.org = o; r.pur = p; r.amt = a; r.len = l;
    return r;
  endfunction

  function automatic disp_exp_t mk_disp(input logic [1:0] r, input logic [9:0] v);
    disp_exp_t d;
    d.res = r; d.inv = v; d.len = DISPLAY_CYCLES;
    return d;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int k;
    bus.key_valid = 1'b0; bus.key_data = 4'h0; bus.cancel = 1'b0;
    bus.ack = 1'b0; bus.rsp_result = 2'b00; bus.rsp_inventory = 10'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_disp_fields", {20'd0, bus.disp_result, bus.disp_inventory}, 32'd0);
    chk("rst_req_fields", {12'd0, bus.req_select, bus.req_origin, bus.req_purpose, bus.req_amount}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Inventory display, ack two cycles after req.
    req_q.push_back(mk_req(2'b00, 4'h3, 4'h0, 10'h000, 3));
    disp_q.push_back(mk_disp(2'b01, 10'h1B5));
    key(4'h3); key(4'h0);
    chk("busy_in_issue", 32'(bus.busy), 32'd1);
    wait_req();
    do_ack(2, 2'b01, 10'h1B5, 1'b0);
    wait_idle(DISPLAY_CYCLES + 20);

    // Transfer, ten-cycle ack delay.
    req_q.push_back(mk_req(2'b10, 4'h5, 4'hA, 10'h1F4, 11));
    disp_q.push_back(mk_disp(2'b01, 10'h0AB));
    key(4'h5); key(4'h2); key(4'hA); key(4'h1); key(4'hF); key(4'h4);
    wait_req();
    do_ack(10, 2'b01, 10'h0AB, 1'b0);
    wait_idle(DISPLAY_CYCLES + 20);

    // Withdraw, upper bits of first amount nibble dropped, ack on first req cycle, refused.
    req_q.push_back(mk_req(2'b01, 4'h7, 4'h0, 10'h200, 1));
    disp_q.push_back(mk_disp(2'b00, 10'h0C8));
    key(4'h7); key(4'h1); key(4'hE); key(4'h0); key(4'h0);
    wait_req();
    do_ack(0, 2'b00, 10'h0C8, 1'b0);
    wait_idle(DISPLAY_CYCLES + 20);

    // Exit select: no request, busy drops immediately.
    key(4'h2);
    chk("exit_busy_before", 32'(bus.busy), 32'd1);
    key(4'h3);
    chk("exit_busy_after", 32'(bus.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Inactivity timeout after one key.
    tmo_q.push_back(1);
    key(4'h4);
    for (k = 1; k <= IDLE_TIMEOUT + 10; k++) begin
      @(posedge clk); #1;
      if (bus.timeout_err) break;
    end
    chk("idle_tmo_cycles", 32'(k), 32'(IDLE_TIMEOUT));
    chk("idle_tmo_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Cancel together with a key in GET_AMT1.
    key(4'h6); key(4'h1); key(4'h2);
    bus.cancel = 1'b1; bus.key_valid = 1'b1; bus.key_data = 4'h5;
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.key_valid = 1'b0; bus.key_data = 4'h0;
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Cancel during ISSUE is ignored; max inventory value.
    req_q.push_back(mk_req(2'b00, 4'h9, 4'h0, 10'h000, 4));
    disp_q.push_back(mk_disp(2'b01, 10'h3FF));
    key(4'h9); key(4'h0);
    wait_req();
    do_ack(3, 2'b01, 10'h3FF, 1'b1);
    wait_idle(DISPLAY_CYCLES + 20);

    // Ack never comes: request abandoned, display untouched.
    req_q.push_back(mk_req(2'b01, 4'h8, 4'h0, 10'h3C7, ACK_TIMEOUT));
    tmo_q.push_back(1);
    key(4'h8); key(4'h1); key(4'h3); key(4'hC); key(4'h7);
    wait_req();
    wait_idle(ACK_TIMEOUT + 20);
    chk("acktmo_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("acktmo_disp_fields", {20'd0, bus.disp_result, bus.disp_inventory}, {20'd0, 2'b01, 10'h3FF});
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted mid-ISSUE.
    req_q.push_back(mk_req(2'b10, 4'h1, 4'h6, 10'h012, 4));
    key(4'h1); key(4'h2); key(4'h6); key(4'h0); key(4'h1); key(4'h2);
    wait_req();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.req), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
    chk("tmo_q_drained", 32'(tmo_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/atm_session_controller.md
Name: atm_session_controller

Overview:
- Customer-facing front end for the account/inventory core.
- Collects a transaction as a stream of 4-bit keypad nibbles: account, operation select, optional destination account, optional 10-bit amount.
- Issues one request to the core over a req/ack handshake, then captures the core's result and balance and presents them on display outputs for a fixed time.
- Select encoding is shared with the core: 00 display inventory, 01 withdraw, 10 transfer/deposit to a destination account, 11 exit.

Parameters:
- IDLE_TIMEOUT, 1000: cycles without a key during entry before the session is abandoned.
- ACK_TIMEOUT, 64: cycles `req` may stay high without `ack` before the request is abandoned.
- DISPLAY_CYCLES, 500: cycles `disp_valid` is held after a completed transaction.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_data is valid.
- key_data  in  4  keypad nibble, MSB-first.
- cancel  in  1  user abort.
- req  out  1  request to the account core.
- req_select  out  2  operation code.
- req_origin  out  4  origin account number.
- req_purpose  out  4  destination account number (0 unless select=10).
- req_amount  out  10  transfer amount (0 when select=00).
- ack  in  1  core accepts the request; rsp_* are valid in the same cycle.
- rsp_result  in  2  core status: 01 ok, 00 refused.
- rsp_inventory  in  10  core balance output.
- busy  out  1  session in progress (state is not IDLE).
- disp_valid  out  1  display fields are valid.
- disp_result  out  2  captured rsp_result.
- disp_inventory  out  10  captured rsp_inventory.
- timeout_err  out  1  one-cycle pulse on an inactivity or ack timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-request):
  - state=IDLE.
  - All outputs 0; all captured fields and counters 0.
  - `req` drops with `rst`; the pending transaction is lost.
- States: IDLE, GET_SEL, GET_DEST, GET_AMT0, GET_AMT1, GET_AMT2, ISSUE, SHOW.
- IDLE:
  - key_valid: key_data → origin; go to GET_SEL.
  - cancel is ignored.
- GET_SEL: key_data[1:0] → select, upper two bits ignored. Next state by select:
  - 11: IDLE; no request, no display.
  - 00: ISSUE with purpose=0, amount=0.
  - 01: GET_AMT0 with purpose=0.
  - 10: GET_DEST.
- GET_DEST: key → purpose; go to GET_AMT0.
- Amount entry, three nibbles MSB-first:
  - GET_AMT0: key_data[1:0] → amount[9:8]; upper bits ignored.
  - GET_AMT1: key → amount[7:4].
  - GET_AMT2: key → amount[3:0]; go to ISSUE.
- One nibble is consumed per key_valid cycle; back-to-back keys are legal.
- Entry states (GET_*):
  - Inactivity counter resets on every key and on each state entry.
  - When the counter reaches IDLE_TIMEOUT: go to IDLE, pulse timeout_err for 1 cycle.
  - cancel returns to IDLE on the next edge.
  - cancel and key_valid in the same cycle: cancel wins; the key is discarded.
- ISSUE:
  - `req`=1 from the first cycle; req_* are registered and held stable while `req`=1.
  - key_valid and cancel are ignored; an issued transaction cannot be aborted.
  - ack sampled high:
    - rsp_result → disp_result, rsp_inventory → disp_inventory.
    - `req` goes 0 at the next edge; go to SHOW.
    - Request-to-ack latency is at least 1 cycle; `ack` on the first `req` cycle is legal.
  - ACK_TIMEOUT cycles with no ack: `req` → 0, timeout_err pulse, go to IDLE. disp_* are unchanged and disp_valid stays 0.
- SHOW:
  - disp_valid=1 for DISPLAY_CYCLES cycles, then disp_valid=0 and go to IDLE.
  - cancel ends SHOW early, next edge.
  - key_valid is ignored; no type-ahead.
  - disp_result and disp_inventory hold their values after SHOW until the next capture.
- Outputs:
  - busy = (state != IDLE), registered.
  - `ack` outside ISSUE is ignored.
  - All outputs are registered.
- Counters:
  - Width is clog2 of the largest parameter plus 1.
  - Saturating; no wrap-around.

Test Plan:
- Reset, then keys 3, 0 (select 00); `ack` 2 cycles after `req` with rsp_result=01, rsp_inventory=0x1B5 → req_select=00, origin=3, purpose=0, amount=0; `req` high for exactly 3 cycles; disp_valid high DISPLAY_CYCLES cycles with result 01, inventory 0x1B5.
- Keys 5, 2, 0xA, 1, 0xF, 0x4 (transfer) → req_select=10, origin=5, purpose=0xA, amount=0x1F4 (500); fields stay stable across a 10-cycle ack delay.
- Keys 7, 1, 0xE, 0, 0 (withdraw; upper bits of the first amount nibble ignored) → amount=0x200. rsp_result=00 → disp_result=00.
- Keys 2, 3 (exit) → busy falls within 1 cycle of the select key; `req` never asserts.
- Key 4 followed by IDLE_TIMEOUT idle cycles → timeout_err one pulse, busy=0. cancel asserted together with key_valid in GET_AMT1 → IDLE, no req. cancel during ISSUE → ignored; request completes.
- `ack` held low in ISSUE → `req` drops after ACK_TIMEOUT cycles, timeout_err pulses, disp_valid stays 0. A second run asserts `rst` mid-ISSUE → `req` drops immediately, busy=0.
